gpio_in_filter: RTL

GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

---
 rtl/gpio_in_filter_pkg.sv | 21 ++
 rtl/gpio_in_filter_if.sv | 16 +
 rtl/gpio_in_filter_db_chan.sv | 43 ++++
 rtl/gpio_in_filter.sv | 84 ++++++++
 4 files changed

// File: rtl/gpio_in_filter_pkg.sv
// Shared io constants for the GPIO input path: channel count, debounce defaults,
// register indices and bus direction encoding.
package gpio_in_filter_pkg;

  localparam int GPIO_CH = 8;
  localparam int DB_CNT_W = 16;
  localparam logic [15:0] DB_LIMIT_RST = 16'd1000;

  typedef enum logic [1:0] {
    REG_DB_LIMIT = 2'd0,
    REG_RISE_EN  = 2'd1,
    REG_FALL_EN  = 2'd2,
    REG_IRQ_STAT = 2'd3
  } reg_addr_e;

  typedef enum logic {
    BUS_WRITE = 1'b0,
    BUS_READ  = 1'b1
  } bus_dir_e;

endpackage

// File: rtl/gpio_in_filter_if.sv
// Strobed register bus between a CPU-side master and the GPIO input filter.
interface gpio_in_filter_if;
  import gpio_in_filter_pkg::*;

  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;

  modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_);
  modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_);

endinterface

// File: rtl/gpio_in_filter_db_chan.sv
// One debounced GPIO input: 2-flop synchronizer, saturating mismatch counter, level.
module gpio_db_chan
  import gpio_in_filter_pkg::*;
#(
  parameter int CNT_W = DB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pin,
  input  logic [CNT_W-1:0] limit,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] count;
  logic             expire;

  // rise/fall flag the same edge on which level is about to change
  assign expire = (sync_q[1] != level) && (count >= limit);
  assign rise   = expire && sync_q[1];
  assign fall   = expire && !sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
      count  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      if (sync_q[1] == level) begin
        count <= '0;
      end else if (expire) begin
        level <= sync_q[1];
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input debounce filter with edge-interrupt status, behind a strobed register bus.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int CH = GPIO_CH,
  parameter int CNT_W = DB_CNT_W,
  parameter logic [CNT_W-1:0] DB_RST = CNT_W'(DB_LIMIT_RST)
) (
  input  logic            clk,
  input  logic            reset,
  gpio_in_filter_if.slave bus,
  input  logic [CH-1:0]   pin_in,
  output logic [CH-1:0]   gpio_in,
  output logic            irq
);

  logic [CNT_W-1:0] db_limit;
  logic [CH-1:0]    rise_en, fall_en, irq_stat;
  logic [CH-1:0]    rise, fall, set_mask, clr_mask;
  logic             access, wr_en, rd_en;
  logic [31:0]      rd_mux;
  logic             unused_wr_data;

  assign access         = !bus.cs_ && !bus.as_;
  assign wr_en          = access && (bus.rw == BUS_WRITE);
  assign rd_en          = access && (bus.rw == BUS_READ);
  assign unused_wr_data = ^bus.wr_data;

  genvar i;
  generate
    for (i = 0; i < CH; i++) begin : g_chan
      gpio_db_chan #(.CNT_W(CNT_W)) u_chan (
        .clk   (clk),
        .reset (reset),
        .pin   (pin_in[i]),
        .limit (db_limit),
        .level (gpio_in[i]),
        .rise  (rise[i]),
        .fall  (fall[i])
      );
    end
  endgenerate

  // A new edge event outranks a simultaneous software clear of the same bit
  assign set_mask = (rise & rise_en) | (fall & fall_en);
  assign clr_mask = (wr_en && bus.addr == REG_IRQ_STAT) ? bus.wr_data[CH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      REG_DB_LIMIT: rd_mux = 32'(db_limit);
      REG_RISE_EN:  rd_mux = 32'(rise_en);
      REG_FALL_EN:  rd_mux = 32'(fall_en);
      REG_IRQ_STAT: rd_mux = 32'(irq_stat);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_limit    <= DB_RST;
      rise_en     <= '0;
      fall_en     <= '0;
      irq_stat    <= '0;
      irq         <= 1'b0;
      bus.rd_data <= '0;
      bus.rdy_    <= 1'b1;
    end else begin
      if (wr_en) begin
        case (bus.addr)
          REG_DB_LIMIT: db_limit <= bus.wr_data[CNT_W-1:0];
          REG_RISE_EN:  rise_en  <= bus.wr_data[CH-1:0];
          REG_FALL_EN:  fall_en  <= bus.wr_data[CH-1:0];
          default:      ;
        endcase
      end
      irq_stat    <= (irq_stat & ~clr_mask) | set_mask;
      irq         <= |irq_stat;
      bus.rdy_    <= !access;
      bus.rd_data <= rd_en ? rd_mux : '0;
    end
  end

endmodule
